// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled UART receiver with mid-bit start qualification, parity/framing/overrun status and valid/ready delivery
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 baud_tick,
  output logic [DATA_BITS-1:0] rx_DATA,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state_q, state_d;
  logic sync_q, rxs_q, armed_q, armed_d, stop_q, stop_d, perr_q, perr_d, ferr_q, ferr_d, complete;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, done_q, done_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      armed_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sync_q  <= rxd;
      rxs_q   <= sync_q;
      armed_q <= armed_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end
  // armed_q demands a high sample in IDLE, so a held-low break line cannot retrigger
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    armed_d  = armed_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    sh_d     = sh_q;
    complete = 1'b0;
    if (baud_tick) begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          armed_d = armed_q | rxs_q;
          if (!rxs_q && armed_q) begin
            state_d = START;
            armed_d = 1'b0;
          end
        end
        START: if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = rxs_q ? IDLE : DATA;
        end
        DATA: if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          stop_d = 1'b0;
          if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? PAR : STOP;
        end
        PAR: if (cnt_q == LAST) begin
          cnt_d   = '0;
          perr_d  = (^{sh_q, rxs_q}) ^ (PARITY == 1);
          state_d = STOP;
        end
        STOP: if (cnt_q == LAST) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rxs_q;
          stop_d = stop_q + 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    if (complete && !(valid_q && !rx_ready)) begin
      data_d  = sh_q;
      valid_d = 1'b1;
      pe_d    = perr_q;
      fe_d    = ferr_d;
      done_d  = 1'b1;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
    end
  end
  assign rx_DATA     = data_q;
  assign rx_valid    = valid_q;
  assign rx_done     = done_q;
  assign parity_err  = pe_q;
  assign frame_err   = fe_q;
  assign overrun_err = ovr_q;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: randomized frames on 8N1, 8E1 and 5N2 receivers checked against a frame-level model
module tb_uart_rx_oversampled;
  localparam int OS = 16;
  logic clk, rst, rxd, baud_tick, rx_ready;
  logic [7:0] d8, de;
  logic [4:0] d5;
  logic v8, dn8, pe8, fe8, ov8, ve, dne, pee, fee, ove, v5, dn5, pe5, fe5, ov5;
  int tests, fails, tick_div, tc;
  int n_done8, n_ov8, n_v8, n_donee, n_done5;
  logic [7:0] cap_d8, cap_de;
  logic [4:0] cap_d5;
  logic cap_pe8, cap_fe8, cap_pee, cap_fee, cap_pe5, cap_fe5;

  uart_rx_oversampled u8 (.clock(clk), .reset(rst), .rxd(rxd), .baud_tick(baud_tick), .rx_DATA(d8), .rx_valid(v8),
    .rx_ready(rx_ready), .rx_done(dn8), .parity_err(pe8), .frame_err(fe8), .overrun_err(ov8));
  uart_rx_oversampled #(.PARITY(2)) ue (.clock(clk), .reset(rst), .rxd(rxd), .baud_tick(baud_tick), .rx_DATA(de),
    .rx_valid(ve), .rx_ready(rx_ready), .rx_done(dne), .parity_err(pee), .frame_err(fee), .overrun_err(ove));
  uart_rx_oversampled #(.DATA_BITS(5), .STOP_BITS(2)) u5 (.clock(clk), .reset(rst), .rxd(rxd), .baud_tick(baud_tick),
    .rx_DATA(d5), .rx_valid(v5), .rx_ready(rx_ready), .rx_done(dn5), .parity_err(pe5), .frame_err(fe5), .overrun_err(ov5));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    tc = 0;
    baud_tick = 0;
    forever begin
      @(negedge clk);
      tc = (tc + 1) % tick_div;
      baud_tick = (tc == 0);
    end
  end

  always @(negedge clk) begin
    if (dn8) begin n_done8++; cap_d8 = d8; cap_pe8 = pe8; cap_fe8 = fe8; end
    if (dne) begin n_donee++; cap_de = de; cap_pee = pee; cap_fee = fee; end
    if (dn5) begin n_done5++; cap_d5 = d5; cap_pe5 = pe5; cap_fe5 = fe5; end
    if (ov8) n_ov8++;
    if (v8) n_v8++;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    rxd = v;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en, input logic pbit,
                            input int nstop, input logic [1:0] stops, input bit ready_at_stop);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    if (par_en) send_bit(pbit);
    if (ready_at_stop) begin
      @(negedge clk);
      rx_ready = 1'b1;
    end
    for (int i = 0; i < nstop; i++) send_bit(stops[i]);
  endtask

  task automatic settle(input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(1'b1);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int div);
    @(negedge clk);
    rst = 1;
    rxd = 1;
    tick_div = div;
    repeat (3) @(negedge clk);
    rst = 0;
    wait_ticks(2);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1;
    rx_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({d8, v8, dn8, pe8, fe8, ov8} !== 13'h0) begin
      fails++; $display("FAIL reset_u8: got %h, want 0", {d8, v8, dn8, pe8, fe8, ov8});
    end
    tests++;
    if ({de, ve, dne, pee, fee, ove} !== 13'h0) begin
      fails++; $display("FAIL reset_ue: got %h, want 0", {de, ve, dne, pee, fee, ove});
    end
    tests++;
    if ({d5, v5, dn5, pe5, fe5, ov5} !== 10'h0) begin
      fails++; $display("FAIL reset_u5: got %h, want 0", {d5, v5, dn5, pe5, fe5, ov5});
    end
    rst = 0;
  endtask

  task automatic test_basic;
    int b, o, vv;
    do_reset(4);
    rx_ready = 1;
    b = n_done8; o = n_ov8; vv = n_v8;
    send_frame(8'hA5, 8, 0, 0, 1, 2'b11, 0);
    settle(1);
    tests++;
    if (n_done8 - b !== 1) begin fails++; $display("FAIL basic_done_count: got %0d, want 1", n_done8 - b); end
    tests++;
    if (cap_d8 !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h, want a5", cap_d8); end
    tests++;
    if ({cap_pe8, cap_fe8} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b, want 00", {cap_pe8, cap_fe8}); end
    tests++;
    if (n_ov8 - o !== 0) begin fails++; $display("FAIL basic_overrun: got %0d, want 0", n_ov8 - o); end
    tests++;
    if (n_v8 - vv !== 1) begin fails++; $display("FAIL basic_valid_cycles: got %0d, want 1", n_v8 - vv); end
  endtask

  task automatic test_parity;
    int b;
    do_reset(4);
    rx_ready = 1;
    b = n_donee;
    send_frame(8'h37, 8, 1, 1'b1, 1, 2'b11, 0);
    settle(1);
    tests++;
    if (n_donee - b !== 1 || cap_de !== 8'h37 || cap_pee !== 1'b0) begin
      fails++; $display("FAIL parity_good: got n=%0d data=%h pe=%b, want n=1 data=37 pe=0", n_donee - b, cap_de, cap_pee);
    end
    send_frame(8'h37, 8, 1, 1'b0, 1, 2'b11, 0);
    settle(1);
    tests++;
    if (n_donee - b !== 2 || cap_de !== 8'h37 || cap_pee !== 1'b1 || cap_fee !== 1'b0) begin
      fails++; $display("FAIL parity_bad: got n=%0d data=%h pe=%b fe=%b, want n=2 data=37 pe=1 fe=0",
                        n_donee - b, cap_de, cap_pee, cap_fee);
    end
  endtask

  task automatic test_glitch;
    int b;
    do_reset(4);
    rx_ready = 1;
    b = n_done8;
    @(negedge clk);
    rxd = 0;
    wait_ticks(4);
    @(negedge clk);
    rxd = 1;
    wait_ticks(3 * OS);
    tests++;
    if (n_done8 - b !== 0) begin fails++; $display("FAIL glitch_no_done: got %0d, want 0", n_done8 - b); end
    send_frame(8'h5A, 8, 0, 0, 1, 2'b11, 0);
    settle(1);
    tests++;
    if (n_done8 - b !== 1 || cap_d8 !== 8'h5A || cap_fe8 !== 1'b0) begin
      fails++; $display("FAIL glitch_followup: got n=%0d data=%h fe=%b, want n=1 data=5a fe=0", n_done8 - b, cap_d8, cap_fe8);
    end
  endtask

  task automatic test_framing;
    int b;
    do_reset(4);
    rx_ready = 1;
    b = n_done8;
    send_frame(8'h81, 8, 0, 0, 1, 2'b00, 0);
    settle(1);
    tests++;
    if (n_done8 - b !== 1 || cap_d8 !== 8'h81 || cap_fe8 !== 1'b1 || cap_pe8 !== 1'b0) begin
      fails++; $display("FAIL framing: got n=%0d data=%h fe=%b pe=%b, want n=1 data=81 fe=1 pe=0",
                        n_done8 - b, cap_d8, cap_fe8, cap_pe8);
    end
  endtask

  task automatic test_back_to_back;
    int b, o;
    do_reset(4);
    rx_ready = 0;
    b = n_done8; o = n_ov8;
    send_frame(8'h11, 8, 0, 0, 1, 2'b11, 0);
    send_frame(8'h22, 8, 0, 0, 1, 2'b11, 0);
    settle(1);
    tests++;
    if (n_done8 - b !== 1 || n_ov8 - o !== 1) begin
      fails++; $display("FAIL overrun_counts: got done=%0d ovr=%0d, want done=1 ovr=1", n_done8 - b, n_ov8 - o);
    end
    tests++;
    if (d8 !== 8'h11 || v8 !== 1'b1) begin
      fails++; $display("FAIL overrun_held: got data=%h valid=%b, want data=11 valid=1", d8, v8);
    end
    send_frame(8'h33, 8, 0, 0, 1, 2'b11, 1);
    settle(1);
    tests++;
    if (n_done8 - b !== 2 || n_ov8 - o !== 1 || cap_d8 !== 8'h33) begin
      fails++; $display("FAIL ready_frame: got done=%0d ovr=%0d data=%h, want done=2 ovr=1 data=33", n_done8 - b, n_ov8 - o, cap_d8);
    end
    tests++;
    if (d8 !== 8'h33 || v8 !== 1'b0) begin
      fails++; $display("FAIL ready_after: got data=%h valid=%b, want data=33 valid=0", d8, v8);
    end
  endtask

  task automatic test_reset_midframe;
    int b, b5;
    do_reset(4);
    rx_ready = 0;
    send_frame(8'h3C, 8, 0, 0, 1, 2'b11, 0);
    settle(1);
    tests++;
    if (v8 !== 1'b1 || d8 !== 8'h3C) begin
      fails++; $display("FAIL midreset_pre: got valid=%b data=%h, want valid=1 data=3c", v8, d8);
    end
    b = n_done8;
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    @(negedge clk);
    wait_ticks(OS / 2);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    tests++;
    if ({d8, v8, dn8, pe8, fe8, ov8} !== 13'h0) begin
      fails++; $display("FAIL midreset_outputs: got %h, want 0", {d8, v8, dn8, pe8, fe8, ov8});
    end
    rst = 0;
    wait_ticks(12 * OS);
    tests++;
    if (n_done8 - b !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d, want 0", n_done8 - b); end
    rx_ready = 1;
    b5 = n_done5;
    send_frame(8'h0F, 5, 0, 0, 2, 2'b11, 0);
    settle(1);
    tests++;
    if (n_done5 - b5 !== 1 || cap_d5 !== 5'h0F || cap_fe5 !== 1'b0) begin
      fails++; $display("FAIL midreset_followup: got n=%0d data=%h fe=%b, want n=1 data=0f fe=0", n_done5 - b5, cap_d5, cap_fe5);
    end
  endtask

  task automatic test_random;
    int divs[3] = '{1, 2, 4};
    int b;
    logic [7:0] data;
    logic pbit, s, exp_pe, exp_fe;
    logic [1:0] st;
    for (int k = 0; k < 3; k++) begin
      do_reset(divs[k]);
      rx_ready = 1;
      repeat (4) begin
        data = 8'($urandom);
        pbit = 1'($urandom);
        s = ($urandom_range(0, 3) != 0);
        exp_pe = (($countones(data) + int'(pbit)) % 2) != 0;
        exp_fe = !s;
        b = n_donee;
        send_frame(data, 8, 1, pbit, 1, {1'b1, s}, 0);
        settle(10);
        tests++;
        if (n_donee - b !== 1 || cap_de !== data || cap_pee !== exp_pe || cap_fee !== exp_fe) begin
          fails++; $display("FAIL rand_8e1: got n=%0d data=%h pe=%b fe=%b, want n=1 data=%h pe=%b fe=%b",
                            n_donee - b, cap_de, cap_pee, cap_fee, data, exp_pe, exp_fe);
        end
        data = {3'b000, 5'($urandom)};
        st = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
        exp_fe = (st != 2'b11);
        b = n_done5;
        send_frame(data, 5, 0, 0, 2, st, 0);
        settle(10);
        tests++;
        if (n_done5 - b !== 1 || cap_d5 !== data[4:0] || cap_pe5 !== 1'b0 || cap_fe5 !== exp_fe) begin
          fails++; $display("FAIL rand_5n2: got n=%0d data=%h pe=%b fe=%b, want n=1 data=%h pe=0 fe=%b",
                            n_done5 - b, cap_d5, cap_pe5, cap_fe5, data[4:0], exp_fe);
        end
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; tick_div = 4;
    n_done8 = 0; n_ov8 = 0; n_v8 = 0; n_donee = 0; n_done5 = 0;
    rst = 1; rxd = 1; rx_ready = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Parametrised UART receive engine, the next generation of the team's `uart_receiver`. It oversamples `rxd` on an external `baud_tick` strobe and qualifies the start bit mid-bit. Supports configurable data width, parity and stop bits. Delivers each frame with parity, framing and overrun status over a valid/ready handshake. It sits between the pad-side serial input and the byte consumer (FIFO or register bank), fed by the shared baud generator.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal 5–8; LSB first on the line.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `OVERSAMPLE`, default 16: `baud_tick` pulses per bit period; even, ≥ 4.
- `clock`, input, 1: single system clock; all logic on its rising edge.
- `reset`, input, 1: reset is synchronous and active-high.
- `rxd`, input, 1: asynchronous serial line; idle high.
- `baud_tick`, input, 1: one-`clock` strobe at OVERSAMPLE × baud rate.
- `rx_DATA`, output, DATA_BITS: last accepted frame's data; stable while `rx_valid`.
- `rx_valid`, output, 1: frame held for consumer; cleared by `rx_ready`.
- `rx_ready`, input, 1: consumer accepts `rx_DATA` when `rx_valid & rx_ready`.
- `rx_done`, output, 1: one-cycle pulse when a frame loads into `rx_DATA`.
- `parity_err`, output, 1: parity mismatch of held frame; 0 when PARITY = 0.
- `frame_err`, output, 1: any stop bit sampled 0 in held frame.
- `overrun_err`, output, 1: one-cycle pulse when a frame completes while `rx_valid` stays held.

## Operation
- `rxd` passes through a 2-flop synchroniser, preset to 1 on reset. All sampling uses the synchronised value `rxs`.
- Tick counter `cnt` (width clog2(OVERSAMPLE)) advances only on cycles with `baud_tick` = 1.
- The state machine has five states: IDLE, START, DATA, PAR, STOP.
- IDLE: on a tick with `rxs` = 0, set `cnt` = 0 and go to START.
- START: sample on the tick where `cnt` = OVERSAMPLE/2−1.
  - `rxs` = 1: false start; return to IDLE with no outputs.
  - Otherwise: set `cnt` = 0, `bit_idx` = 0, go to DATA.
- DATA: on the tick where `cnt` = OVERSAMPLE−1, shift `rxs` into the MSB of the shift register. The register is right-shifting, so the result is LSB-first.
  - Increment `bit_idx` and reset `cnt`.
  - After DATA_BITS samples, go to PAR if PARITY ≠ 0, else STOP.
- PAR: sample at `cnt` = OVERSAMPLE−1.
  - Even parity: error if XOR(data, parity bit) = 1.
  - Odd parity: error if XOR(data, parity bit) = 0.
- STOP: sample STOP_BITS times at `cnt` = OVERSAMPLE−1. Any 0 sets the frame error.
  - After the last stop sample, complete the frame and return to IDLE directly, mid-stop-bit. This allows back-to-back frames with no idle gap.
- Completion when `rx_valid` = 0, or `rx_valid` = 1 with `rx_ready` = 1 in the same cycle:
  - Load `rx_DATA`, `parity_err` and `frame_err`.
  - Set `rx_valid` = 1 and pulse `rx_done`.
- Completion when `rx_valid` = 1 and `rx_ready` = 0:
  - Discard the new frame; held data and flags are unchanged.
  - Pulse `overrun_err`. `rx_done` stays 0.
- `rx_valid & rx_ready` with no completion that cycle: clear `rx_valid`. `parity_err` and `frame_err` clear with it.
- A frame with `frame_err` is still delivered. `rxd` held low (break) produces frame_err frames of all zeros, then waits in IDLE for a high-to-low edge. IDLE requires `rxs` = 1 seen for at least one tick before re-arming.

## Timing
- Reset (synchronous, any state, including mid-frame):
  - State goes to IDLE; `cnt` and `bit_idx` clear.
  - `rx_DATA` = 0, `rx_valid` = 0, `rx_done` = 0, `parity_err` = 0, `frame_err` = 0, `overrun_err` = 0.
  - The synchroniser resets to 1. Any partial frame is dropped.
- Input latency: 2 `clock` cycles from `rxd` to `rxs`.
- Output latency: `rx_done`/`rx_valid` assert on the `clock` edge after the tick that samples the final stop bit. All flags are registered.
- Frame time, start edge to completion: (OVERSAMPLE/2) + OVERSAMPLE·(DATA_BITS + P + STOP_BITS − 1) + OVERSAMPLE ticks, ±1 tick of edge uncertainty. P = 1 if PARITY ≠ 0, else 0.
- `baud_tick` held high continuously is legal: `cnt` advances every cycle.
- `rx_ready` is ignored when `rx_valid` = 0.

## Test plan
- Frame 0xA5, 8N1, OVERSAMPLE = 16, `baud_tick` every 4 clocks, `rx_ready` = 1:
  - `rx_DATA` = 0xA5; `rx_done` pulses once; `rx_valid` high 1 cycle.
  - `parity_err` = `frame_err` = `overrun_err` = 0.
- PARITY = 2 (even):
  - Send 0x37 with parity bit 1: `parity_err` = 0.
  - Send 0x37 with parity bit 0: `rx_DATA` = 0x37, `parity_err` = 1.
- Glitch and false start: pulse `rxd` low for 4 ticks (< OVERSAMPLE/2) -> no `rx_done`; FSM back in IDLE. A following valid frame 0x5A receives correctly.
- Framing: send 0x81 with stop bit 0 -> `rx_DATA` = 0x81, `frame_err` = 1.
- Overrun and back-to-back: hold `rx_ready` = 0 and send 0x11 then 0x22 with no gap -> `rx_DATA` = 0x11 stays held, `overrun_err` pulses once. With `rx_ready` = 1 asserted the same cycle 0x33 completes -> `rx_DATA` = 0x33, no overrun.
- Reset mid-frame: assert `reset` during DATA bit 3 of 0xFF -> all outputs 0 next cycle, no `rx_done`. A subsequent frame 0x0F (DATA_BITS = 5, STOP_BITS = 2) gives `rx_DATA` = 0x0F.
